// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: BCD digit, 7-bit binary value and the converter-arbiter FSM states.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] bin_t;

   localparam bcd_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {IDLE, CONV, RESP} conv_state_t;

endpackage

// File: rtl/bcd_to_binary.sv
// Combinational single-digit BCD to binary converter.
module bcd_to_binary
   import stopwatch_pkg::*;
(
   input  bcd_t bcd,
   output bin_t bin
);

   assign bin = {3'b000, bcd};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bcd_to_binary converter between N_REQ digit requesters,
// sequenced accept -> convert -> respond with rsp_valid/rsp_ready backpressure.
module bcd_conv_arbiter
   import stopwatch_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [4*N_REQ-1:0] req_bcd,
   output logic [N_REQ-1:0]   req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [6:0]         rsp_bin,
   output logic               rsp_err,
   output logic               busy
);

   conv_state_t     state, state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] rr_nxt;
   logic [ID_W-1:0] id_q;
   bcd_t            bcd_q;
   bin_t            conv_bin;
   logic            accept;

   // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  ptr);
      logic [N_REQ-1:0] rot;
      int unsigned      j;
      int unsigned      kk;
      int unsigned      k_sel;
      int unsigned      sel;
      rot   = '0;
      k_sel = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         j = (32'(ptr) + k) % N_REQ;
         rot[k[ID_W-1:0]] = v[j[ID_W-1:0]];
      end
      for (int unsigned k = N_REQ; k > 0; k--) begin
         kk = k - 1;
         if (rot[kk[ID_W-1:0]]) k_sel = kk;
      end
      sel = (32'(ptr) + k_sel) % N_REQ;
      return sel[ID_W-1:0];
   endfunction

   assign grant  = rr_pick(req_valid, rr_ptr);
   assign rr_nxt = (32'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
   assign busy   = (state != IDLE);

   bcd_to_binary u_conv (
      .bcd (bcd_q),
      .bin (conv_bin)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // req_ready is gated by rst_n so no accept is signalled while reset is held.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      req_ready = '0;
      unique case (state)
         IDLE: begin
            if (rst_n && (|req_valid)) begin
               accept           = 1'b1;
               req_ready[grant] = 1'b1;
               state_nxt        = CONV;
            end
         end
         CONV: state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         id_q      <= '0;
         bcd_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_bin   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            bcd_q  <= req_bcd[{grant, 2'b00} +: 4];
            id_q   <= grant;
            rr_ptr <= rr_nxt;
         end
         if (state == CONV) begin
            rsp_bin   <= (bcd_q <= BCD_MAX) ? conv_bin : '0;
            rsp_err   <= (bcd_q > BCD_MAX);
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with a transaction-level reference model.
module tb_bcd_conv_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_bcd;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [6:0]  rsp_bin;
   logic        rsp_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   bcd_conv_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_bcd   (req_bcd),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_bin   (rsp_bin),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int ptr);
      int j;
      for (int k = 0; k < 4; k++) begin
         j = (ptr + k) % 4;
         if (v[j[1:0]]) return j;
      end
      return 0;
   endfunction

   function automatic int dig(input logic [15:0] b, input int i);
      logic [15:0] t;
      t = b >> (4 * i);
      return int'(t[3:0]);
   endfunction

   // Reference model: one transaction in flight, stage 1 = converting, stage 2 = offering response.
   bit m_busy, m_valid, m_err;
   int m_rr, m_id, m_dig, m_bin, m_stage;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_valid <= 0; m_rr <= 0; m_stage <= 0;
         m_id <= 0; m_bin <= 0; m_err <= 0; m_dig <= 0;
      end else if (!m_busy) begin
         if (|req_valid) begin
            m_id    <= pick(req_valid, m_rr);
            m_dig   <= dig(req_bcd, pick(req_valid, m_rr));
            m_rr    <= (pick(req_valid, m_rr) + 1) % 4;
            m_busy  <= 1;
            m_stage <= 1;
         end
      end else if (m_stage == 1) begin
         m_valid <= 1;
         m_err   <= (m_dig > 9);
         m_bin   <= (m_dig > 9) ? 0 : m_dig;
         m_stage <= 2;
      end else if (rsp_ready) begin
         m_valid <= 0;
         m_busy  <= 0;
         m_stage <= 0;
      end
   end

   int         cyc_n = 0;
   logic [3:0] rr_n  = '0;
   int         log_id[$];
   int         log_bin[$];
   int         log_cyc[$];

   initial begin
      logic [3:0] exp_rdy;
      forever begin
         @(negedge clk);
         cyc_n++;
         rr_n = req_ready;
         if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy",      32'(busy), 0);
            chk("rst_rsp_id",    32'(rsp_id), 0);
            chk("rst_rsp_bin",   32'(rsp_bin), 0);
            chk("rst_rsp_err",   32'(rsp_err), 0);
         end else begin
            exp_rdy = '0;
            if (!m_busy && (|req_valid)) exp_rdy = 4'(1 << pick(req_valid, m_rr));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("busy",      32'(busy), 32'(m_busy));
            if (m_valid) begin
               chk("rsp_id",  32'(rsp_id), m_id);
               chk("rsp_bin", 32'(rsp_bin), m_bin);
               chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (rsp_valid && rsp_ready) begin
               log_id.push_back(int'(rsp_id));
               log_bin.push_back(int'(rsp_bin));
               log_cyc.push_back(cyc_n);
            end
         end
      end
   end

   // Advance one cycle; a requester drops its strobe once it has seen its req_ready.
   task automatic cyc();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~rr_n;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || rsp_valid) && n < 20) begin
         cyc();
         n++;
      end
      chk("idle_reached", 32'(busy | rsp_valid), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n0;
      int exp_b[4];
      exp_b = '{3, 5, 9, 0};

      // reset with every requester asking
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_bcd   = {4'd0, 4'd9, 4'd5, 4'd3};
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("t1_req_ready", 32'(req_ready), 0);
      chk("t1_rsp_valid", 32'(rsp_valid), 0);
      chk("t1_busy",      32'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_first_grant", 32'(req_ready), 32'b0001);

      // all four, responses in id order one per 3 cycles
      n = 0;
      while (log_id.size() < 4 && n < 40) begin
         cyc();
         n++;
      end
      chk("t3_count", 32'(log_id.size()), 4);
      if (log_id.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t3_id",  log_id[i], i);
            chk("t3_bin", log_bin[i], exp_b[i]);
            if (i > 0) chk("t3_spacing", log_cyc[i] - log_cyc[i-1], 3);
         end
      end
      req_valid = 4'hF;
      @(negedge clk);
      chk("t3_wrap_to_0", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = 4'b0000;
      wait_idle();

      // single request on id 2
      req_bcd   = {4'd0, 4'd7, 4'd0, 4'd0};
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t2_ready", 32'(req_ready), 32'b0100);
      cyc(); @(negedge clk);
      chk("t2_not_yet", 32'(rsp_valid), 0);
      cyc(); @(negedge clk);
      chk("t2_valid", 32'(rsp_valid), 1);
      chk("t2_id",    32'(rsp_id), 2);
      chk("t2_bin",   32'(rsp_bin), 7);
      chk("t2_err",   32'(rsp_err), 0);
      cyc();
      wait_idle();

      // backpressure with id 1 pending behind id 0
      req_bcd   = {4'd0, 4'd9, 4'd5, 4'd3};
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      @(negedge clk);
      chk("t4_grant0", 32'(req_ready), 32'b0001);
      for (int t = 1; t <= 7; t++) begin
         cyc(); @(negedge clk);
         chk("t4_no_ready", 32'(req_ready), 0);
         if (t >= 2) begin
            chk("t4_valid", 32'(rsp_valid), 1);
            chk("t4_id",    32'(rsp_id), 0);
            chk("t4_bin",   32'(rsp_bin), 3);
         end
      end
      cyc();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_hs_cycle_ready", 32'(req_ready), 0);
      cyc(); @(negedge clk);
      chk("t4_next_grant", 32'(req_ready), 32'b0010);
      cyc();
      wait_idle();

      // invalid digit, changed after accept
      req_bcd   = {4'd0, 4'd0, 4'hB, 4'd0};
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t5_ready", 32'(req_ready), 32'b0010);
      cyc();
      req_bcd = {4'd0, 4'd0, 4'h2, 4'd0};
      @(negedge clk);
      cyc(); @(negedge clk);
      chk("t5_valid", 32'(rsp_valid), 1);
      chk("t5_id",    32'(rsp_id), 1);
      chk("t5_err",   32'(rsp_err), 1);
      chk("t5_bin",   32'(rsp_bin), 0);
      cyc();
      wait_idle();

      // reset while in RESP
      rsp_ready = 1'b0;
      req_bcd   = {4'd6, 4'd0, 4'd0, 4'd0};
      req_valid = 4'b1000;
      @(negedge clk);
      chk("t6_ready", 32'(req_ready), 32'b1000);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      chk("t6_valid_before_rst", 32'(rsp_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_resp_rst_valid", 32'(rsp_valid), 0);
      chk("t6_resp_rst_busy",  32'(busy), 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'b0000;
      n0 = log_id.size();
      repeat (5) cyc();
      chk("t6_no_stale_resp", 32'(log_id.size()), 32'(n0));

      // reset while in CONV, pointer returns to 0
      req_bcd   = {4'd0, 4'd4, 4'd0, 4'd0};
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t6c_ready", 32'(req_ready), 32'b0100);
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_conv_rst_valid", 32'(rsp_valid), 0);
      chk("t6_conv_rst_busy",  32'(busy), 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      req_bcd   = {4'd0, 4'd0, 4'd0, 4'd8};
      req_valid = 4'hF;
      @(negedge clk);
      chk("t6_rr_reset", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = 4'b0000;
      repeat (2) cyc();
      wait_idle();
      chk("t6_one_resp", 32'(log_id.size()), 32'(n0 + 1));
      if (log_id.size() == n0 + 1) begin
         chk("t6_last_id",  log_id[n0], 0);
         chk("t6_last_bin", log_bin[n0], 8);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
